// File: rtl/enemy_spawner.sv
// Enemy wave spawner: releases a wave of enemies into four on-screen slots,
// one every SPAWN_DELAY frames, and tracks kills until the wave is cleared.
module enemy_spawner #(
  parameter int TOTAL_ENEMIES = 20,
  parameter int MAX_ACTIVE    = 4,
  parameter int SPAWN_DELAY   = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       kill_valid,
  input  logic [1:0] kill_slot,
  input  logic       spawn_blocked,
  output logic [3:0] slot_active,
  output logic       spawn_valid,
  output logic [1:0] spawn_slot,
  output logic [1:0] spawn_point,
  output logic       scoring,
  output logic [5:0] num_enemies,
  output logic       wave_clear
);

  typedef enum logic [1:0] {IDLE, DELAY, SPAWN, CLEAR} state_t;

  localparam logic [3:0] ALL_SLOTS = 4'((1 << MAX_ACTIVE) - 1);
  localparam logic [5:0] RESERVE_INIT = 6'(TOTAL_ENEMIES);
  localparam logic [7:0] DELAY_INIT = 8'(SPAWN_DELAY);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] reserve_q, reserve_d;
  logic [1:0] point_q, point_d;
  logic [3:0] slot_active_q, slot_active_d;
  logic       spawn_valid_q, spawn_valid_d;
  logic [1:0] spawn_slot_q, spawn_slot_d;
  logic [1:0] spawn_point_q, spawn_point_d;
  logic       scoring_q, scoring_d;
  logic [5:0] num_enemies_q, num_enemies_d;
  logic       wave_clear_q, wave_clear_d;

  logic [1:0] free_idx;
  logic       kill_ok;
  logic [3:0] kill_mask;
  logic [3:0] slots_after_kill;
  logic [7:0] cnt_next;
  logic [2:0] active_count;

  // Lowest-index free slot, chosen from the slot map before this frame's kill.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!slot_active_q[i]) free_idx = 2'(i);
    end
  end

  // Next-state logic: start overrides everything, then the per-state wave behaviour.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reserve_d     = reserve_q;
    point_d       = point_q;
    slot_active_d = slot_active_q;
    spawn_valid_d = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    spawn_point_d = spawn_point_q;
    scoring_d     = 1'b0;
    wave_clear_d  = wave_clear_q;

    kill_ok          = kill_valid && slot_active_q[kill_slot] &&
                       (state_q == DELAY || state_q == SPAWN);
    kill_mask        = kill_ok ? (4'b0001 << kill_slot) : 4'b0000;
    slots_after_kill = slot_active_q & ~kill_mask;
    cnt_next         = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

    if (start) begin
      state_d       = DELAY;
      cnt_d         = DELAY_INIT;
      reserve_d     = RESERVE_INIT;
      point_d       = 2'd0;
      slot_active_d = 4'b0000;
      wave_clear_d  = 1'b0;
    end else begin
      case (state_q)
        DELAY: begin
          scoring_d     = kill_ok;
          slot_active_d = slots_after_kill;
          cnt_d         = cnt_next;
          if (cnt_next == 8'd0 && reserve_q != 6'd0 && slots_after_kill != ALL_SLOTS)
            state_d = SPAWN;
        end
        SPAWN: begin
          scoring_d     = kill_ok;
          slot_active_d = slots_after_kill;
          if (slot_active_q == ALL_SLOTS || reserve_q == 6'd0) begin
            state_d = DELAY;
            cnt_d   = 8'd0;
          end else if (!spawn_blocked) begin
            slot_active_d = slots_after_kill | (4'b0001 << free_idx);
            spawn_valid_d = 1'b1;
            spawn_slot_d  = free_idx;
            spawn_point_d = point_q;
            reserve_d     = reserve_q - 6'd1;
            point_d       = (point_q == 2'd2) ? 2'd0 : point_q + 2'd1;
            cnt_d         = DELAY_INIT;
            state_d       = DELAY;
          end
        end
        default: begin
        end
      endcase

      if ((state_q == DELAY || state_q == SPAWN) &&
          reserve_d == 6'd0 && slot_active_d == 4'b0000) begin
        state_d      = CLEAR;
        wave_clear_d = 1'b1;
      end
    end
  end

  // Remaining enemy count is reserve plus the number of live slots after this frame.
  always_comb begin
    active_count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      active_count = active_count + {2'b00, slot_active_d[i]};
    end
    num_enemies_d = reserve_d + 6'(active_count);
  end

  // State and registered outputs; reset abandons any wave in progress.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      reserve_q     <= RESERVE_INIT;
      point_q       <= 2'd0;
      slot_active_q <= 4'b0000;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= 2'd0;
      spawn_point_q <= 2'd0;
      scoring_q     <= 1'b0;
      num_enemies_q <= RESERVE_INIT;
      wave_clear_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reserve_q     <= reserve_d;
      point_q       <= point_d;
      slot_active_q <= slot_active_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_point_q <= spawn_point_d;
      scoring_q     <= scoring_d;
      num_enemies_q <= num_enemies_d;
      wave_clear_q  <= wave_clear_d;
    end
  end

  assign slot_active = slot_active_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_slot  = spawn_slot_q;
  assign spawn_point = spawn_point_q;
  assign scoring     = scoring_q;
  assign num_enemies = num_enemies_q;
  assign wave_clear  = wave_clear_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Testbench for enemy_spawner: a small-wave instance driven from a vector
// table, plus a default-sized instance exercised with directed sequences.
module tb_enemy_spawner;

  logic frame_clk;
  logic Reset;

  // Default instance (20 enemies, 120-frame delay)
  logic       start, kill_valid, spawn_blocked;
  logic [1:0] kill_slot;
  logic [3:0] slot_active;
  logic       spawn_valid, scoring, wave_clear;
  logic [1:0] spawn_slot, spawn_point;
  logic [5:0] num_enemies;

  // Small instance (2 enemies, 3-frame delay)
  logic       start2, kill_valid2, spawn_blocked2;
  logic [1:0] kill_slot2;
  logic [3:0] slot_active2;
  logic       spawn_valid2, scoring2, wave_clear2;
  logic [1:0] spawn_slot2, spawn_point2;
  logic [5:0] num_enemies2;

  int tests_run = 0;
  int tests_failed = 0;

  enemy_spawner dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start),
    .kill_valid(kill_valid), .kill_slot(kill_slot), .spawn_blocked(spawn_blocked),
    .slot_active(slot_active), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
    .spawn_point(spawn_point), .scoring(scoring), .num_enemies(num_enemies),
    .wave_clear(wave_clear)
  );

  enemy_spawner #(.TOTAL_ENEMIES(2), .MAX_ACTIVE(4), .SPAWN_DELAY(3)) dut2 (
    .frame_clk(frame_clk), .Reset(Reset), .start(start2),
    .kill_valid(kill_valid2), .kill_slot(kill_slot2), .spawn_blocked(spawn_blocked2),
    .slot_active(slot_active2), .spawn_valid(spawn_valid2), .spawn_slot(spawn_slot2),
    .spawn_point(spawn_point2), .scoring(scoring2), .num_enemies(num_enemies2),
    .wave_clear(wave_clear2)
  );

  // Free-running frame clock, rising edges at 5, 15, 25, ...
  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // Hard stop in case the sequence below stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       start;
    logic       kv;
    logic [1:0] ks;
    logic       blk;
    logic [3:0] e_slots;
    logic       e_sv;
    logic [1:0] e_slot;
    logic [1:0] e_pt;
    logic       e_sc;
    logic [5:0] e_num;
    logic       e_wc;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step_frame();
    @(posedge frame_clk);
    #1;
  endtask

  // Drive one table row into the small instance, clock it, and compare
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    start2 = v.start;
    kill_valid2 = v.kv;
    kill_slot2 = v.ks;
    spawn_blocked2 = v.blk;
    step_frame();
    start2 = 1'b0;
    kill_valid2 = 1'b0;
    spawn_blocked2 = 1'b0;
    checkOutput({tag, " slot_active"}, int'(slot_active2), int'(v.e_slots));
    checkOutput({tag, " spawn_valid"}, int'(spawn_valid2), int'(v.e_sv));
    checkOutput({tag, " scoring"}, int'(scoring2), int'(v.e_sc));
    checkOutput({tag, " num_enemies"}, int'(num_enemies2), int'(v.e_num));
    checkOutput({tag, " wave_clear"}, int'(wave_clear2), int'(v.e_wc));
    if (v.e_sv) begin
      checkOutput({tag, " spawn_slot"}, int'(spawn_slot2), int'(v.e_slot));
      checkOutput({tag, " spawn_point"}, int'(spawn_point2), int'(v.e_pt));
    end
  endtask

  // Step the default instance until it spawns or the frame budget runs out
  task automatic wait_spawn(input int max_frames, output int frames);
    frames = 0;
    do begin
      step_frame();
      frames++;
    end while (!spawn_valid && frames < max_frames);
  endtask

  // Step n frames, counting any spawn or scoring pulses seen
  task automatic run_quiet(input int n, output int spawns, output int scores);
    spawns = 0;
    scores = 0;
    for (int i = 0; i < n; i++) begin
      step_frame();
      if (spawn_valid) spawns++;
      if (scoring) scores++;
    end
  endtask

  task automatic check_spawn(input string name, input int slot, input int pt,
                             input int slots, input int num);
    checkOutput({name, " spawn_valid"}, int'(spawn_valid), 1);
    checkOutput({name, " spawn_slot"}, int'(spawn_slot), slot);
    checkOutput({name, " spawn_point"}, int'(spawn_point), pt);
    checkOutput({name, " slot_active"}, int'(slot_active), slots);
    checkOutput({name, " num_enemies"}, int'(num_enemies), num);
  endtask

  initial begin
    int frames, spawns, scores;

    vecs[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b1, 6'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1, 6'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b0, 6'd2, 1'b0};

    Reset = 1'b1;
    start = 1'b0; kill_valid = 1'b0; kill_slot = 2'd0; spawn_blocked = 1'b0;
    start2 = 1'b0; kill_valid2 = 1'b0; kill_slot2 = 2'd0; spawn_blocked2 = 1'b0;
    #12;
    Reset = 1'b0;
    #1;

    // Reset state of both instances
    checkOutput("reset slot_active", int'(slot_active), 0);
    checkOutput("reset spawn_valid", int'(spawn_valid), 0);
    checkOutput("reset spawn_slot", int'(spawn_slot), 0);
    checkOutput("reset spawn_point", int'(spawn_point), 0);
    checkOutput("reset scoring", int'(scoring), 0);
    checkOutput("reset num_enemies", int'(num_enemies), 20);
    checkOutput("reset wave_clear", int'(wave_clear), 0);
    checkOutput("reset2 num_enemies", int'(num_enemies2), 2);

    // Small wave: spawn, block, stray kill, kill+spawn, clear, restart
    for (int i = 0; i < 19; i++) applyStimulus(i, vecs[i]);

    // First spawn lands 121 frames after start
    start = 1'b1;
    step_frame();
    start = 1'b0;
    wait_spawn(300, frames);
    checkOutput("first spawn latency", frames, 121);
    check_spawn("spawn1", 0, 0, 4'b0001, 20);

    // Kill aimed at an empty slot is ignored
    kill_valid = 1'b1; kill_slot = 2'd3;
    step_frame();
    kill_valid = 1'b0;
    checkOutput("stray kill scoring", int'(scoring), 0);
    checkOutput("stray kill num_enemies", int'(num_enemies), 20);
    checkOutput("stray kill slot_active", int'(slot_active), 1);

    // Second spawn held off by spawn_blocked for 5 frames
    run_quiet(119, spawns, scores);
    checkOutput("pre-block spawns", spawns, 0);
    spawn_blocked = 1'b1;
    run_quiet(5, spawns, scores);
    spawn_blocked = 1'b0;
    checkOutput("blocked spawns", spawns, 0);
    checkOutput("blocked num_enemies", int'(num_enemies), 20);
    step_frame();
    check_spawn("spawn2", 1, 1, 4'b0011, 20);

    // Third spawn coincides with a kill of slot 0
    run_quiet(120, spawns, scores);
    checkOutput("pre-spawn3 spawns", spawns, 0);
    kill_valid = 1'b1; kill_slot = 2'd0;
    step_frame();
    kill_valid = 1'b0;
    check_spawn("spawn3", 2, 2, 4'b0110, 19);
    checkOutput("spawn3 scoring", int'(scoring), 1);

    // Fill the remaining slots
    wait_spawn(300, frames);
    checkOutput("spawn4 latency", frames, 121);
    check_spawn("spawn4", 0, 0, 4'b0111, 19);
    checkOutput("spawn4 scoring", int'(scoring), 0);
    wait_spawn(300, frames);
    checkOutput("spawn5 latency", frames, 121);
    check_spawn("spawn5", 3, 1, 4'b1111, 19);

    // No spawn while all slots are full
    run_quiet(300, spawns, scores);
    checkOutput("full spawns", spawns, 0);

    // Kill slot 2, which is then refilled
    kill_valid = 1'b1; kill_slot = 2'd2;
    step_frame();
    kill_valid = 1'b0;
    checkOutput("kill2 scoring", int'(scoring), 1);
    checkOutput("kill2 slot_active", int'(slot_active), 4'b1011);
    checkOutput("kill2 num_enemies", int'(num_enemies), 18);
    wait_spawn(300, frames);
    checkOutput("refill latency", frames, 1);
    checkOutput("refill scoring", int'(scoring), 0);
    check_spawn("refill", 2, 2, 4'b1111, 18);

    // Asynchronous reset mid-wave, between clock edges
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("async reset slot_active", int'(slot_active), 0);
    checkOutput("async reset spawn_valid", int'(spawn_valid), 0);
    checkOutput("async reset num_enemies", int'(num_enemies), 20);
    checkOutput("async reset scoring", int'(scoring), 0);
    checkOutput("async reset spawn_slot", int'(spawn_slot), 0);
    #2;
    Reset = 1'b0;
    kill_valid = 1'b1; kill_slot = 2'd0;
    run_quiet(5, spawns, scores);
    kill_valid = 1'b0;
    checkOutput("post-reset spawns", spawns, 0);
    checkOutput("post-reset scores", scores, 0);
    checkOutput("post-reset num_enemies", int'(num_enemies), 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
